// File: rtl/prog_reflector.sv
// Runtime-rewirable reflector: registered one-hot letter reflection through an active
// pairing table, plus a load/check/commit engine for installing a new involution atomically.
module prog_reflector #(
    parameter int N = 26,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         d_valid,
    input  logic [N-1:0] d,
    output logic         out_valid,
    output logic [N-1:0] out,
    output logic         out_err,
    input  logic         cfg_start,
    input  logic         pair_valid,
    output logic         pair_ready,
    input  logic [W-1:0] pair_a,
    input  logic [W-1:0] pair_b,
    output logic         busy,
    output logic         cfg_done,
    output logic         cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic [4:0] REFL_B [26] = '{
        5'd24, 5'd17, 5'd20, 5'd7,  5'd16, 5'd18, 5'd11, 5'd3,  5'd15, 5'd23,
        5'd13, 5'd6,  5'd14, 5'd10, 5'd12, 5'd8,  5'd4,  5'd1,  5'd5,  5'd25,
        5'd2,  5'd22, 5'd21, 5'd9,  5'd0,  5'd19
    };

    // Power-up pairing: Reflector B for the classic alphabet, neighbour swap otherwise.
    function automatic logic [W-1:0] default_map(input int idx);
        logic [W-1:0] r;
        if ((N == 26) && (idx < 26)) begin
            r = W'(REFL_B[idx]);
        end else begin
            r = W'(idx ^ 32'd1);
        end
        return r;
    endfunction

    state_t         state_r, state_nxt_s;
    logic [W-1:0]   active_r  [N];
    logic [W-1:0]   staging_r [N];
    logic [N-1:0]   assigned_r;
    logic [W-1:0]   cnt_r, k_r;
    logic           err_pending_r, chk_fail_r;
    logic           pair_ready_r, busy_r, cfg_done_r, cfg_err_r;
    logic           out_valid_r, out_err_r;
    logic [N-1:0]   out_r;

    logic           is_onehot_s;
    logic [W-1:0]   idx_s;
    logic [N-1:0]   refl_s;
    logic           a_in_s, b_in_s, pair_bad_s;
    logic [W-1:0]   partner_s, back_s;
    logic           p_in_s, entry_fail_s;
    logic           clear_s, good_s, bad_s, commit_s, reject_s;

    // Decode the incoming letter and look up its partner in the active table.
    always_comb begin
        is_onehot_s = ($countones(d) == 32'd1);
        idx_s       = '0;
        for (int i = 0; i < N; i++) begin
            if (d[i]) begin
                idx_s = W'(i);
            end else begin
                idx_s = idx_s;
            end
        end
        for (int i = 0; i < N; i++) begin
            refl_s[i] = (active_r[idx_s] == W'(i));
        end
    end

    // Pair legality and per-entry involution check of the staging table.
    always_comb begin
        a_in_s     = (32'(pair_a) < 32'(N));
        b_in_s     = (32'(pair_b) < 32'(N));
        pair_bad_s = (pair_a == pair_b) || !a_in_s || !b_in_s;
        if (a_in_s && b_in_s) begin
            pair_bad_s = pair_bad_s || assigned_r[pair_a] || assigned_r[pair_b];
        end else begin
            pair_bad_s = 1'b1;
        end
        partner_s = staging_r[k_r];
        p_in_s    = (32'(partner_s) < 32'(N));
        if (p_in_s) begin
            back_s = staging_r[partner_s];
        end else begin
            back_s = '0;
        end
        entry_fail_s = !assigned_r[k_r] || (partner_s == k_r) || !p_in_s || (back_s != k_r);
    end

    // Configuration FSM next-state and control strobes.
    always_comb begin
        state_nxt_s = state_r;
        clear_s     = 1'b0;
        good_s      = 1'b0;
        bad_s       = 1'b0;
        commit_s    = 1'b0;
        reject_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_nxt_s = ST_LOAD;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cfg_start) begin
                    clear_s = 1'b1;
                end else if (pair_valid && pair_bad_s) begin
                    bad_s = 1'b1;
                end else if (pair_valid) begin
                    good_s = 1'b1;
                    if (cnt_r == W'(N / 2 - 1)) begin
                        state_nxt_s = ST_CHECK;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_CHECK: begin
                if (k_r == W'(N - 1)) begin
                    state_nxt_s = ST_IDLE;
                    if (chk_fail_r || entry_fail_s || err_pending_r) begin
                        reject_s = 1'b1;
                    end else begin
                        commit_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_CHECK;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state and registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pair_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            cfg_done_r   <= 1'b0;
            cfg_err_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pair_ready_r <= (state_nxt_s == ST_LOAD);
            busy_r       <= (state_nxt_s != ST_IDLE);
            cfg_done_r   <= commit_s;
            cfg_err_r    <= reject_s;
        end
    end

    // Staging table, bookkeeping and check walker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                staging_r[i] <= '0;
            end
            assigned_r    <= '0;
            cnt_r         <= '0;
            err_pending_r <= 1'b0;
            k_r           <= '0;
            chk_fail_r    <= 1'b0;
        end else begin
            if (clear_s) begin
                assigned_r    <= '0;
                cnt_r         <= '0;
                err_pending_r <= 1'b0;
            end else if (bad_s) begin
                err_pending_r <= 1'b1;
            end else if (good_s) begin
                staging_r[pair_a]  <= pair_b;
                staging_r[pair_b]  <= pair_a;
                assigned_r[pair_a] <= 1'b1;
                assigned_r[pair_b] <= 1'b1;
                cnt_r              <= cnt_r + W'(32'd1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (state_r == ST_CHECK) begin
                k_r        <= k_r + W'(32'd1);
                chk_fail_r <= chk_fail_r || entry_fail_s;
            end else begin
                k_r        <= '0;
                chk_fail_r <= 1'b0;
            end
        end
    end

    // Active table: whole-table copy on commit so lookups never see a mix.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                active_r[i] <= default_map(i);
            end
        end else if (commit_s) begin
            for (int i = 0; i < N; i++) begin
                active_r[i] <= staging_r[i];
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                active_r[i] <= active_r[i];
            end
        end
    end

    // Reflect path; data outputs hold while no letter is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_r       <= '0;
            out_err_r   <= 1'b0;
        end else begin
            out_valid_r <= d_valid;
            if (d_valid) begin
                out_r     <= is_onehot_s ? refl_s : '0;
                out_err_r <= !is_onehot_s;
            end else begin
                out_r     <= out_r;
                out_err_r <= out_err_r;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign out        = out_r;
    assign out_err    = out_err_r;
    assign pair_ready = pair_ready_r;
    assign busy       = busy_r;
    assign cfg_done   = cfg_done_r;
    assign cfg_err    = cfg_err_r;

endmodule
